switch_port: RTL and testbench

SWITCH_PORT -- requirements
Module: switch_port

---
 rtl/port_if.sv | 40 ++++
 rtl/switch_port.sv | 207 ++++++++++++++++++++
 tb/tb_switch_port.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/port_if.sv
// Switch port bundle: one byte-wide input stream (driver -> switch, with stall)
// and one byte-wide output stream (switch -> monitor).
interface port_if (
    input logic clk,
    input logic reset
);
    logic       valid_in;
    logic [7:0] data_in;
    logic       suspend_in;
    logic       valid_out;
    logic [7:0] data_out;

    // Traffic side: drives the input stream, observes stall and output stream.
    modport master (
        output valid_in,
        output data_in,
        input  suspend_in,
        input  valid_out,
        input  data_out
    );

    // Switch side: consumes the input stream, drives stall and output stream.
    modport slave (
        input  valid_in,
        input  data_in,
        output suspend_in,
        output valid_out,
        output data_out
    );

    // Prints every output byte of this port as it appears.
    task automatic monitor(input int id);
        forever begin
            @(posedge clk);
            if (valid_out) begin
                $display("%0t port%0d data_out=%02h", $time, id, data_out);
            end
        end
    endtask
endinterface

// File: rtl/switch_port.sv
// Four-port byte switch. Each input carries packets of a header byte
// (mask in [3:0], payload length in [7:4]) followed by that many payload bytes.
// An input waits in REQ until every output in its mask is free, then owns
// those outputs for the duration of the packet. Round-robin arbitration.
module switch_port (
    input logic   clk,
    input logic   reset,
    port_if.slave port0,
    port_if.slave port1,
    port_if.slave port2,
    port_if.slave port3
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    // Header field helpers.
    function automatic logic [3:0] hdr_mask(input logic [7:0] hdr);
        return hdr[3:0];
    endfunction

    function automatic logic [3:0] hdr_len(input logic [7:0] hdr);
        return hdr[7:4];
    endfunction

    // Per-input state
    state_e     state_r [4];
    state_e     state_s [4];
    logic [7:0] hdr_r   [4];
    logic [7:0] hdr_s   [4];
    logic [3:0] cnt_r   [4];
    logic [3:0] cnt_s   [4];

    // Per-output ownership
    logic [3:0] own_r;
    logic [3:0] own_s;
    logic [1:0] owner_r [4];
    logic [1:0] owner_s [4];

    // Arbitration
    logic [1:0] rr_r;
    logic [1:0] rr_s;
    logic [3:0] grant_s;
    logic [1:0] arb_idx_s;
    logic [3:0] arb_taken_s;
    logic       arb_ok_s;

    // Registered port outputs
    logic [3:0] susp_r;
    logic [3:0] susp_s;
    logic [3:0] vout_r;
    logic [3:0] vout_s;
    logic [7:0] dout_r  [4];
    logic [7:0] dout_s  [4];
    logic       out_hit_s;

    // Gathered inputs
    logic [3:0] vin_s;
    logic [7:0] din_s   [4];
    logic [3:0] xfer_s;

    // Collect the four input streams into indexable form.
    always_comb begin
        vin_s    = {port3.valid_in, port2.valid_in, port1.valid_in, port0.valid_in};
        din_s[0] = port0.data_in;
        din_s[1] = port1.data_in;
        din_s[2] = port2.data_in;
        din_s[3] = port3.data_in;
    end

    // A byte moves only when presented and the port was not stalling.
    assign xfer_s = vin_s & ~susp_r;

    assign port0.suspend_in = susp_r[0];
    assign port1.suspend_in = susp_r[1];
    assign port2.suspend_in = susp_r[2];
    assign port3.suspend_in = susp_r[3];
    assign port0.valid_out  = vout_r[0];
    assign port1.valid_out  = vout_r[1];
    assign port2.valid_out  = vout_r[2];
    assign port3.valid_out  = vout_r[3];
    assign port0.data_out   = dout_r[0];
    assign port1.data_out   = dout_r[1];
    assign port2.data_out   = dout_r[2];
    assign port3.data_out   = dout_r[3];

    // Round-robin scan from rr: grant each requester whose whole mask is free
    // of owned outputs and of outputs already granted in this scan.
    always_comb begin
        grant_s     = 4'd0;
        arb_taken_s = 4'd0;
        arb_idx_s   = 2'd0;
        arb_ok_s    = 1'b0;
        rr_s        = rr_r;
        for (int k = 0; k < 4; k++) begin
            arb_idx_s = rr_r + 2'(k);
            arb_ok_s  = (state_r[arb_idx_s] == ST_REQ) &&
                        ((hdr_mask(hdr_r[arb_idx_s]) & (own_r | arb_taken_s)) == 4'd0);
            grant_s[arb_idx_s] = arb_ok_s;
            arb_taken_s = arb_taken_s | (arb_ok_s ? hdr_mask(hdr_r[arb_idx_s]) : 4'd0);
            rr_s        = arb_ok_s ? (arb_idx_s + 2'd1) : rr_s;
        end
    end

    // Per-input packet FSM next state, header capture and byte counting.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_s[i] = state_r[i];
            hdr_s[i]   = hdr_r[i];
            cnt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (xfer_s[i]) begin
                        hdr_s[i] = din_s[i];
                        cnt_s[i] = hdr_len(din_s[i]);
                        if (hdr_mask(din_s[i]) != 4'd0) begin
                            state_s[i] = ST_REQ;
                        end else if (hdr_len(din_s[i]) != 4'd0) begin
                            state_s[i] = ST_DROP;
                        end else begin
                            state_s[i] = ST_IDLE;
                        end
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (grant_s[i]) begin
                        state_s[i] = (cnt_r[i] == 4'd0) ? ST_IDLE : ST_FWD;
                    end else begin
                        state_s[i] = ST_REQ;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (xfer_s[i]) begin
                        cnt_s[i]   = cnt_r[i] - 4'd1;
                        state_s[i] = (cnt_r[i] == 4'd1) ? ST_IDLE : state_r[i];
                    end else begin
                        state_s[i] = state_r[i];
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                end
            endcase
            susp_s[i] = (state_s[i] == ST_REQ);
        end
    end

    // Output datapath: owned outputs follow their owner's accepted bytes,
    // free outputs show a granted header; ownership is kept only while the
    // owner stays in FWD, and zero-length packets never take ownership.
    always_comb begin
        out_hit_s = 1'b0;
        for (int o = 0; o < 4; o++) begin
            own_s[o]   = 1'b0;
            owner_s[o] = owner_r[o];
            vout_s[o]  = 1'b0;
            dout_s[o]  = 8'h00;
            if (own_r[o]) begin
                vout_s[o] = xfer_s[owner_r[o]];
                dout_s[o] = xfer_s[owner_r[o]] ? din_s[owner_r[o]] : 8'h00;
                own_s[o]  = (state_s[owner_r[o]] == ST_FWD);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    out_hit_s  = grant_s[i] & hdr_r[i][o];
                    vout_s[o]  = vout_s[o] | out_hit_s;
                    dout_s[o]  = dout_s[o] | (out_hit_s ? hdr_r[i] : 8'h00);
                    own_s[o]   = own_s[o] | (out_hit_s & (hdr_len(hdr_r[i]) != 4'd0));
                    owner_s[o] = out_hit_s ? 2'(i) : owner_s[o];
                end
            end
        end
    end

    // State, ownership and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_r   <= 2'd0;
            own_r  <= 4'd0;
            susp_r <= 4'd0;
            vout_r <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= ST_IDLE;
                hdr_r[i]   <= 8'h00;
                cnt_r[i]   <= 4'd0;
                owner_r[i] <= 2'd0;
                dout_r[i]  <= 8'h00;
            end
        end else begin
            rr_r   <= rr_s;
            own_r  <= own_s;
            susp_r <= susp_s;
            vout_r <= vout_s;
            for (int i = 0; i < 4; i++) begin
                state_r[i] <= state_s[i];
                hdr_r[i]   <= hdr_s[i];
                cnt_r[i]   <= cnt_s[i];
                owner_r[i] <= owner_s[i];
                dout_r[i]  <= dout_s[i];
            end
        end
    end
endmodule

// File: tb/tb_switch_port.sv
// Directed bench for switch_port: unicast, multicast, contention, concurrent
// disjoint traffic, drop, zero-length loopback and reset mid-packet.
module tb_switch_port;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    port_if p0 (.clk(clk), .reset(reset));
    port_if p1 (.clk(clk), .reset(reset));
    port_if p2 (.clk(clk), .reset(reset));
    port_if p3 (.clk(clk), .reset(reset));

    switch_port dut (
        .clk   (clk),
        .reset (reset),
        .port0 (p0),
        .port1 (p1),
        .port2 (p2),
        .port3 (p3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int p, input logic v, input logic [7:0] d);
        case (p)
            0: begin p0.valid_in = v; p0.data_in = d; end
            1: begin p1.valid_in = v; p1.data_in = d; end
            2: begin p2.valid_in = v; p2.data_in = d; end
            default: begin p3.valid_in = v; p3.data_in = d; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ev,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input logic [3:0] es);
        chk({tag, ".valid"},   {12'd0, p3.valid_out, p2.valid_out, p1.valid_out, p0.valid_out}, {12'd0, ev});
        chk({tag, ".data0"},   {8'd0, p0.data_out}, {8'd0, e0});
        chk({tag, ".data1"},   {8'd0, p1.data_out}, {8'd0, e1});
        chk({tag, ".data2"},   {8'd0, p2.data_out}, {8'd0, e2});
        chk({tag, ".data3"},   {8'd0, p3.data_out}, {8'd0, e3});
        chk({tag, ".suspend"}, {12'd0, p3.suspend_in, p2.suspend_in, p1.suspend_in, p0.suspend_in}, {12'd0, es});
    endtask

    initial begin
        for (int p = 0; p < 4; p++) drv(p, 1'b0, 8'h00);

        // Reset state
        reset = 1'b1;
        step(); step();
        chk_all("reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        reset = 1'b0;

        // Unicast port0 -> port1
        drv(0, 1'b1, 8'h22); step();
        chk_all("uni_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
        drv(0, 1'b1, 8'hA1); step();
        chk_all("uni_hdr", 4'b0010, 8'h00, 8'h22, 8'h00, 8'h00, 4'b0000);
        step();
        chk_all("uni_pl1", 4'b0010, 8'h00, 8'hA1, 8'h00, 8'h00, 4'b0000);
        drv(0, 1'b1, 8'hB2); step();
        chk_all("uni_pl2", 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 4'b0000);
        drv(0, 1'b0, 8'h00); step();
        chk_all("uni_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Multicast port2 -> ports 0,2,3
        drv(2, 1'b1, 8'h1D); step();
        chk_all("mc_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0100);
        drv(2, 1'b1, 8'h5C); step();
        chk_all("mc_hdr", 4'b1101, 8'h1D, 8'h00, 8'h1D, 8'h1D, 4'b0000);
        step();
        chk_all("mc_pl", 4'b1101, 8'h5C, 8'h00, 8'h5C, 8'h5C, 4'b0000);
        drv(2, 1'b0, 8'h00); step();
        chk_all("mc_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Contention on port2 with rr back at 0
        reset = 1'b1; step();
        chk_all("reset2", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        reset = 1'b0;
        drv(0, 1'b1, 8'h14); drv(3, 1'b1, 8'h14); step();
        chk_all("ct_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1001);
        drv(0, 1'b1, 8'h77); drv(3, 1'b1, 8'h99); step();
        chk_all("ct_hdr0", 4'b0100, 8'h00, 8'h00, 8'h14, 8'h00, 4'b1000);
        chk("ct_rr", {14'd0, dut.rr_r}, 16'd1);
        step();
        chk_all("ct_pl0", 4'b0100, 8'h00, 8'h00, 8'h77, 8'h00, 4'b1000);
        drv(0, 1'b0, 8'h00); step();
        chk_all("ct_hdr3", 4'b0100, 8'h00, 8'h00, 8'h14, 8'h00, 4'b0000);
        step();
        chk_all("ct_pl3", 4'b0100, 8'h00, 8'h00, 8'h99, 8'h00, 4'b0000);
        drv(3, 1'b0, 8'h00); step();
        chk_all("ct_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Concurrent disjoint: port0 -> port1, port2 -> port3
        drv(0, 1'b1, 8'h12); drv(2, 1'b1, 8'h18); step();
        chk_all("cc_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0101);
        drv(0, 1'b1, 8'hAA); drv(2, 1'b1, 8'hBB); step();
        chk_all("cc_hdr", 4'b1010, 8'h00, 8'h12, 8'h00, 8'h18, 4'b0000);
        step();
        chk_all("cc_pl", 4'b1010, 8'h00, 8'hAA, 8'h00, 8'hBB, 4'b0000);
        drv(0, 1'b0, 8'h00); drv(2, 1'b0, 8'h00); step();
        chk_all("cc_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Drop on port1, then a real packet port1 -> port0
        drv(1, 1'b1, 8'h20); step();
        chk_all("dr_hdr", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        drv(1, 1'b1, 8'h11); step();
        chk_all("dr_b1", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        drv(1, 1'b1, 8'h22); step();
        chk_all("dr_b2", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        drv(1, 1'b1, 8'h11); step();
        chk_all("dr_next_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010);
        drv(1, 1'b1, 8'h33); step();
        chk_all("dr_next_hdr", 4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 4'b0000);
        step();
        chk_all("dr_next_pl", 4'b0001, 8'h33, 8'h00, 8'h00, 8'h00, 4'b0000);
        drv(1, 1'b0, 8'h00); step();
        chk_all("dr_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Zero-length loopback on port3
        drv(3, 1'b1, 8'h08); step();
        chk_all("lb_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000);
        drv(3, 1'b0, 8'h00); step();
        chk_all("lb_hdr", 4'b1000, 8'h00, 8'h00, 8'h00, 8'h08, 4'b0000);
        step();
        chk_all("lb_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Reset during FWD after one of three payload bytes
        drv(0, 1'b1, 8'h32); step();
        chk_all("rs_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
        drv(0, 1'b1, 8'h01); step();
        chk_all("rs_hdr", 4'b0010, 8'h00, 8'h32, 8'h00, 8'h00, 4'b0000);
        step();
        chk_all("rs_pl1", 4'b0010, 8'h00, 8'h01, 8'h00, 8'h00, 4'b0000);
        drv(0, 1'b1, 8'h02); reset = 1'b1; step();
        chk_all("rs_reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        drv(0, 1'b0, 8'h00); reset = 1'b0; step();
        chk_all("rs_after", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        drv(0, 1'b1, 8'h04); step();
        chk_all("rs_new_acc", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
        drv(0, 1'b0, 8'h00); step();
        chk_all("rs_new_hdr", 4'b0100, 8'h00, 8'h00, 8'h04, 8'h00, 4'b0000);
        step();
        chk_all("rs_new_end", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
